// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO with edge capture, per-bit glitch filter, interrupt mask
// and a saturating edge counter. Single clock domain, synchronous reset.
module pio_in_edge_irq #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned DEBOUNCE    = 0,
  parameter int unsigned DEB_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [2:0] AddrData  = 3'd0;
  localparam logic [2:0] AddrMask  = 3'd2;
  localparam logic [2:0] AddrCap   = 3'd3;
  localparam logic [2:0] AddrCount = 3'd4;

  logic                                wr;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]   sync_q;
  logic [WIDTH-1:0]                    sync_s;
  logic [WIDTH-1:0]                    filt_q;
  logic [WIDTH-1:0]                    filt_dly_q;
  logic [WIDTH-1:0]                    edge_det;
  logic [WIDTH-1:0]                    irqmask_q, irqmask_d;
  logic [WIDTH-1:0]                    capture_q, capture_d;
  logic [15:0]                         count_q, count_d;
  logic [31:0]                         readdata_q, readdata_d;
  logic [5:0]                          edge_pop;
  logic [16:0]                         count_sum;
  logic                                unused_wdata;

  // Bits of writedata above WIDTH have no function.
  assign unused_wdata = ^writedata;

  assign wr     = chipselect & ~write_n;
  assign sync_s = sync_q[SYNC_STAGES-1];

  function automatic logic [5:0] popcount(input logic [WIDTH-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

  // Input synchroniser chain; stage 0 samples the asynchronous pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  if (DEBOUNCE <= 1) begin : g_nofilt
    // Filtered level simply follows the synchroniser output.
    always_ff @(posedge clk) begin
      if (reset) begin
        filt_q <= '0;
      end else begin
        filt_q <= sync_s;
      end
    end
  end else begin : g_filt
    localparam logic [DEB_W-1:0] DebLast = DEB_W'(DEBOUNCE - 1);

    logic [WIDTH-1:0][DEB_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]            filt_d;

    // Per-bit counter of consecutive cycles the input disagrees with the filtered level.
    always_comb begin
      filt_d = filt_q;
      cnt_d  = cnt_q;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_s[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == DebLast) begin
          filt_d[i] = sync_s[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + DEB_W'(1);
        end
      end
    end

    // Filter state registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        filt_q <= '0;
        cnt_q  <= '0;
      end else begin
        filt_q <= filt_d;
        cnt_q  <= cnt_d;
      end
    end
  end

  // Delayed copy of the filtered level for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_dly_q <= '0;
    end else begin
      filt_dly_q <= filt_q;
    end
  end

  // Edge selection by configured polarity.
  always_comb begin
    if (EDGE_TYPE == 0) begin
      edge_det = filt_q & ~filt_dly_q;
    end else if (EDGE_TYPE == 1) begin
      edge_det = ~filt_q & filt_dly_q;
    end else begin
      edge_det = filt_q ^ filt_dly_q;
    end
  end

  assign edge_pop  = popcount(edge_det);
  assign count_sum = {1'b0, count_q} + 17'(edge_pop);

  // Register next-state: mask write, W1C capture (new edge beats clear), saturating count.
  always_comb begin
    irqmask_d = irqmask_q;
    if (wr && address == AddrMask) begin
      irqmask_d = writedata[WIDTH-1:0];
    end

    if (wr && address == AddrCap) begin
      capture_d = edge_det | (capture_q & ~writedata[WIDTH-1:0]);
    end else begin
      capture_d = edge_det | capture_q;
    end

    if (wr && address == AddrCount) begin
      count_d = 16'(edge_pop);
    end else if (count_sum[16]) begin
      count_d = 16'hFFFF;
    end else begin
      count_d = count_sum[15:0];
    end
  end

  // Read mux, registered every cycle regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    case (address)
      AddrData:  readdata_d = 32'(filt_q);
      AddrMask:  readdata_d = 32'(irqmask_q);
      AddrCap:   readdata_d = 32'(capture_q);
      AddrCount: readdata_d = 32'(count_q);
      default:   readdata_d = '0;
    endcase
  end

  // Control/status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      irqmask_q  <= '0;
      capture_q  <= '0;
      count_q    <= '0;
      readdata_q <= '0;
    end else begin
      irqmask_q  <= irqmask_d;
      capture_q  <= capture_d;
      count_q    <= count_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(capture_q & irqmask_q);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: two configurations driven by the same bus/pins,
// a reference model per configuration, and a tag-ordered scoreboard.
module tb_pio_in_edge_irq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port = '0;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;

  always #5 clk = ~clk;

  pio_in_edge_irq #(
    .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .DEBOUNCE(0), .DEB_W(16)
  ) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_port), .irq(irq_a)
  );

  pio_in_edge_irq #(
    .WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(2), .DEBOUNCE(5), .DEB_W(4)
  ) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b), .in_port(in_port), .irq(irq_b)
  );

  // Configuration of each modelled instance.
  int stg [2] = '{2, 3};
  int etp [2] = '{0, 2};
  int deb [2] = '{0, 5};

  // Reference model state: pin history (index 0 = most recent sample), filtered level,
  // previous filtered level, disagreement run length per bit, registers.
  logic [7:0] m_hist [2][4];
  logic [7:0] m_f [2];
  logic [7:0] m_fp [2];
  int         m_run [2][8];
  logic [7:0] m_mask [2];
  logic [7:0] m_cap [2];
  int         m_cnt [2];

  typedef struct {
    int          tag;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        irq_a;
    logic        irq_b;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc_cnt = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic model_clear(input int k);
    for (int j = 0; j < 4; j++) m_hist[k][j] = '0;
    for (int b = 0; b < 8; b++) m_run[k][b] = 0;
    m_f[k] = '0; m_fp[k] = '0; m_mask[k] = '0; m_cap[k] = '0; m_cnt[k] = 0;
  endtask

  // Advance one clock edge using the inputs currently driven; return the outputs
  // the DUT should show after that edge.
  task automatic model_step(input int k, output logic [31:0] rd, output logic irq_e);
    logic [7:0] s, ed, nf;
    logic       wr;
    int         n;
    if (reset) begin
      model_clear(k);
      rd = '0;
      irq_e = 1'b0;
      return;
    end
    case (address)
      3'd0:    rd = {24'h0, m_f[k]};
      3'd2:    rd = {24'h0, m_mask[k]};
      3'd3:    rd = {24'h0, m_cap[k]};
      3'd4:    rd = m_cnt[k];
      default: rd = '0;
    endcase
    s = m_hist[k][stg[k]-1];
    if (etp[k] == 0)      ed = m_f[k] & ~m_fp[k];
    else if (etp[k] == 1) ed = ~m_f[k] & m_fp[k];
    else                  ed = m_f[k] ^ m_fp[k];
    wr = chipselect && !write_n;
    n = $countones(ed);
    if (wr && address == 3'd3) m_cap[k] = ed | (m_cap[k] & ~writedata[7:0]);
    else                       m_cap[k] = ed | m_cap[k];
    if (wr && address == 3'd2) m_mask[k] = writedata[7:0];
    if (wr && address == 3'd4) m_cnt[k] = n;
    else                       m_cnt[k] = (m_cnt[k] + n > 65535) ? 65535 : m_cnt[k] + n;
    // The filtered level adopts s once s has disagreed for deb cycles in a row.
    nf = m_f[k];
    for (int b = 0; b < 8; b++) begin
      if (deb[k] <= 1) nf[b] = s[b];
      else if (s[b] == m_f[k][b]) m_run[k][b] = 0;
      else if (m_run[k][b] + 1 >= deb[k]) begin
        nf[b] = s[b];
        m_run[k][b] = 0;
      end else m_run[k][b] = m_run[k][b] + 1;
    end
    m_fp[k] = m_f[k];
    m_f[k] = nf;
    for (int j = 3; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
    m_hist[k][0] = in_port;
    irq_e = |(m_cap[k] & m_mask[k]);
  endtask

  // One bus cycle: drive inputs away from the edge and queue the expected response.
  task automatic cyc(input logic rst, input logic [7:0] pin, input logic cs, input logic wn,
                     input logic [2:0] a, input logic [31:0] wd);
    exp_t x;
    @(negedge clk);
    reset = rst; in_port = pin; chipselect = cs; write_n = wn; address = a; writedata = wd;
    x.tag = cyc_cnt;
    model_step(0, x.rd_a, x.irq_a);
    model_step(1, x.rd_b, x.irq_b);
    exp_q.push_back(x);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] pin);
    cyc(1'b0, pin, 1'b1, 1'b1, a, $urandom);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [7:0] pin);
    cyc(1'b0, pin, 1'b1, 1'b0, a, d);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc_cnt, act, req);
    end
  endtask

  // Monitor: compare every response whose edge has already happened.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].tag < cyc_cnt) begin
      e = exp_q.pop_front();
      chk("readdata_a", rd_a, e.rd_a);
      chk("readdata_b", rd_b, e.rd_b);
      chk("irq_a", {31'h0, irq_a}, {31'h0, e.irq_a});
      chk("irq_b", {31'h0, irq_b}, {31'h0, e.irq_b});
    end
  end

  initial begin
    logic [7:0] pin;
    logic [2:0] a;
    for (int k = 0; k < 2; k++) model_clear(k);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h00, 1'b0, 1'b1, 3'd0, 32'h0);
    for (int i = 0; i < 4; i++) rd(3'(i + 1), 8'h00);

    // Short pulse on bit 3, then observe data/capture/count.
    for (int i = 0; i < 4; i++) rd(3'd0, 8'h08);
    for (int i = 0; i < 12; i++) rd(3'(i % 5), 8'h00);

    // Mask bit 3 then clear it via W1C.
    wr(3'd2, 32'hFFFF_FF08, 8'h00);
    rd(3'd3, 8'h00);
    wr(3'd3, 32'h0000_0008, 8'h00);
    for (int i = 0; i < 3; i++) rd(3'd3, 8'h00);

    // Re-arm bit 3, then a new rising edge lands in the same cycle as its W1C.
    for (int i = 0; i < 4; i++) rd(3'd3, 8'h08);
    for (int i = 0; i < 12; i++) rd(3'd3, 8'h00);
    rd(3'd3, 8'h08);
    rd(3'd3, 8'h08);
    rd(3'd3, 8'h08);
    wr(3'd3, 32'h0000_0008, 8'h08);
    for (int i = 0; i < 4; i++) rd(3'd3, 8'h08);
    wr(3'd3, 32'hFFFF_FFFF, 8'h00);

    // Glitch shorter than the filter, then a long-enough pulse, on bit 0.
    for (int i = 0; i < 20; i++) rd(3'(i % 5), 8'h00);
    wr(3'd4, 32'h0, 8'h00);
    wr(3'd3, 32'hFF, 8'h00);
    for (int i = 0; i < 3; i++) rd(3'd3, 8'h01);
    for (int i = 0; i < 14; i++) rd(3'(i % 5), 8'h00);
    for (int i = 0; i < 6; i++) rd(3'd3, 8'h01);
    for (int i = 0; i < 14; i++) rd(3'(i % 5), 8'h00);

    // All bits 0->1->0 with stable holds: any-edge instance counts 16.
    wr(3'd4, 32'h0, 8'h00);
    for (int i = 0; i < 12; i++) rd(3'd4, 8'hFF);
    for (int i = 0; i < 14; i++) rd(3'd4, 8'h00);

    // Randomized traffic with slowly changing pins.
    pin = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) pin = pin ^ 8'($urandom);
      a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 3) wr(a, $urandom, pin);
      else rd(a, pin);
    end

    // Drive count toward saturation by toggling all pins every cycle.
    wr(3'd4, 32'h0, 8'h00);
    for (int i = 0; i < 17000; i++) rd(3'd4, (i % 2 == 0) ? 8'hFF : 8'h00);
    for (int i = 0; i < 6; i++) rd(3'd4, 8'h00);

    // Reset in the middle of a pulse with all pins high.
    wr(3'd2, 32'hFF, 8'hFF);
    for (int i = 0; i < 3; i++) rd(3'd3, 8'hFF);
    cyc(1'b1, 8'hFF, 1'b1, 1'b1, 3'd3, 32'h0);
    cyc(1'b1, 8'hFF, 1'b1, 1'b1, 3'd3, 32'h0);
    for (int i = 0; i < 5; i++) rd(3'(i), 8'hFF);
    for (int i = 0; i < 12; i++) rd(3'd3, 8'hFF);
    wr(3'd2, 32'hFF, 8'hFF);
    rd(3'd3, 8'hFF);
    rd(3'd0, 8'hFF);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
